shared_mem_bank_replay: RTL and testbench

- Shared-memory responder at the far end of the bank-conflict issue stage.
- Accepts the registered lane address, store-data and info packets.
- Serialises conflicting lanes into per-bank passes against internal word-interleaved banks; writes stores; gathers load data into one writeback packet.
- Drives the stall back to the issue stage while replaying, and reports the pass count.

---
 rtl/shared_mem_bank_replay.sv | 230 +++++++++++++++++++++++
 tb/tb_shared_mem_bank_replay.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_bank_replay.sv
// shared_mem_bank_replay
//   Shared-memory responder behind the bank-conflict issue stage. A packet
//   (lane addresses, store data, {mask, warp, valid, load}) is captured while
//   idle. The lanes are then replayed as per-bank passes against
//   word-interleaved banks. Each pass grants the lowest pending lane of each
//   bank. Stores write at the edge, and load data is gathered into one
//   writeback packet.
//
//   Optional build macro: SHARED_MEM_BROADCAST_EN
//     When defined, a load pass also grants every pending load lane that hits
//     the same bank and row as the granted lane. All of those lanes share the
//     one word read.
//
// Ports
//   clk, reset     clock, asynchronous active-low reset
//   addr_pkt_i     lane addresses, lane i at [(NUM_LANE-1-i)*ADDR_W +: ADDR_W]
//   data_pkt_i     store data, same lane packing
//   info_pkt_i     {mask (bit i = lane i), warp, valid, load}
//   stall_o        high while replaying; upstream holds its packet
//   wb_valid_o     one-cycle completion pulse
//   wb_load_o      completed packet was a load
//   wb_warp_o      warp of completed packet
//   wb_mask_o      mask of completed packet
//   wb_data_o      load data (lane packing as addr_pkt_i), 0 for stores and
//                  for masked-off lanes
//   pass_cnt_o     number of passes the completed packet used
//   conflict_o     more than one pass used, only while wb_valid_o is high

// Per-lane address decode: word-interleaved bank select and row within bank.
module shared_mem_lane_dec #(
  parameter int ADDR_W = 32,
  parameter int BLOG   = 4,
  parameter int RLOG   = 8
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [BLOG-1:0]   bank,
  output logic [RLOG-1:0]   row
);
  assign bank = addr[BLOG+1:2];
  assign row  = addr[BLOG+2+RLOG-1:BLOG+2];

  // Byte offset and bits above the bank depth do not select storage.
  logic unusedAddr;
  assign unusedAddr = ^{addr[ADDR_W-1:BLOG+2+RLOG], addr[1:0]};
endmodule

module shared_mem_bank_replay #(
  parameter int NUM_LANE   = 32,
  parameter int NUM_BANK   = 16,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WARP_W     = 5,
  parameter int BANK_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_LANE*ADDR_W-1:0]   addr_pkt_i,
  input  logic [NUM_LANE*DATA_W-1:0]   data_pkt_i,
  input  logic [NUM_LANE+WARP_W+1:0]   info_pkt_i,
  output logic                         stall_o,
  output logic                         wb_valid_o,
  output logic                         wb_load_o,
  output logic [WARP_W-1:0]            wb_warp_o,
  output logic [NUM_LANE-1:0]          wb_mask_o,
  output logic [NUM_LANE*DATA_W-1:0]   wb_data_o,
  output logic [5:0]                   pass_cnt_o,
  output logic                         conflict_o
);
  localparam int BLOG = $clog2(NUM_BANK);
  localparam int RLOG = $clog2(BANK_DEPTH);
  localparam int LLOG = $clog2(NUM_LANE);

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic [NUM_LANE-1:0] mask;
    logic [WARP_W-1:0]   warp;
    logic                valid;
    logic                load;
  } info_t;

  info_t info;
  assign info = info_pkt_i;

  state_t                            state;
  logic [NUM_LANE-1:0][BLOG-1:0]     inBank, bankQ;
  logic [NUM_LANE-1:0][RLOG-1:0]     inRow, rowQ;
  logic [NUM_LANE-1:0][DATA_W-1:0]   inData, dataQ;
  logic [NUM_LANE-1:0][DATA_W-1:0]   result, resultNext;
  logic [NUM_LANE-1:0]               maskQ, pending, grant, pendNext;
  logic [WARP_W-1:0]                 warpQ;
  logic                              loadQ;
  logic [5:0]                        passCnt;
  logic [NUM_LANE*DATA_W-1:0]        wbDataNext;

  // Bank storage; deliberately not reset.
  logic [DATA_W-1:0] mem [NUM_BANK][BANK_DEPTH];

  // Decode the incoming packet so only bank/row need to be held.
  for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
    shared_mem_lane_dec #(.ADDR_W(ADDR_W), .BLOG(BLOG), .RLOG(RLOG)) u_dec (
      .addr (addr_pkt_i[(NUM_LANE-1-i)*ADDR_W +: ADDR_W]),
      .bank (inBank[i]),
      .row  (inRow[i])
    );
    assign inData[i] = data_pkt_i[(NUM_LANE-1-i)*DATA_W +: DATA_W];
    assign wbDataNext[(NUM_LANE-1-i)*DATA_W +: DATA_W] = resultNext[i];
  end

  // Per bank: is any lane pending there, and which is the lowest one.
  // Scanning from the top lane down lets the lowest lane overwrite last.
  logic [NUM_BANK-1:0]               bankHit;
  logic [NUM_BANK-1:0][LLOG-1:0]     bankLane;
  always_comb begin
    bankHit  = '0;
    bankLane = '0;
    for (int i = NUM_LANE-1; i >= 0; i--) begin
      if (pending[i]) begin
        bankHit[bankQ[i]]  = 1'b1;
        bankLane[bankQ[i]] = LLOG'(i);
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
`ifdef SHARED_MEM_BROADCAST_EN
      // Loads that hit the granted lane's word ride along in the same pass.
      grant[i] = pending[i] && ((bankLane[bankQ[i]] == LLOG'(i)) ||
                                (loadQ && (rowQ[bankLane[bankQ[i]]] == rowQ[i])));
`else
      grant[i] = pending[i] && (bankLane[bankQ[i]] == LLOG'(i));
`endif
    end
  end

  // One read port per bank, addressed by that bank's granted lane. All lanes
  // granted in a bank share the same row, so they all take this word.
  logic [NUM_BANK-1:0][RLOG-1:0]   bankRow;
  logic [NUM_BANK-1:0][DATA_W-1:0] bankRd;
  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    assign bankRow[b] = rowQ[bankLane[b]];
    assign bankRd[b]  = mem[b][bankRow[b]];
  end

  always_comb begin
    resultNext = result;
    for (int i = 0; i < NUM_LANE; i++) begin
      if (grant[i] && loadQ) resultNext[i] = bankRd[bankQ[i]];
    end
  end

  assign pendNext = pending & ~grant;

  // Stores write one lane per bank per pass. Lanes hitting the same word
  // therefore land in ascending lane order.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANK; b++) begin
      if (state == ISSUE && !loadQ && bankHit[b]) mem[b][bankRow[b]] <= dataQ[bankLane[b]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bankQ      <= '0;
      rowQ       <= '0;
      dataQ      <= '0;
      maskQ      <= '0;
      warpQ      <= '0;
      loadQ      <= 1'b0;
      pending    <= '0;
      passCnt    <= '0;
      result     <= '0;
      wb_valid_o <= 1'b0;
      wb_load_o  <= 1'b0;
      wb_warp_o  <= '0;
      wb_mask_o  <= '0;
      wb_data_o  <= '0;
      pass_cnt_o <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (info.valid) begin
            bankQ   <= inBank;
            rowQ    <= inRow;
            dataQ   <= inData;
            maskQ   <= info.mask;
            warpQ   <= info.warp;
            loadQ   <= info.load;
            pending <= info.mask;
            passCnt <= '0;
            result  <= '0;
            if (info.mask != '0) begin
              state <= ISSUE;
            end else begin
              // Empty packet: complete at once without touching the banks.
              wb_valid_o <= 1'b1;
              wb_load_o  <= info.load;
              wb_warp_o  <= info.warp;
              wb_mask_o  <= '0;
              wb_data_o  <= '0;
              pass_cnt_o <= '0;
            end
          end
        end
        ISSUE: begin
          pending <= pendNext;
          passCnt <= passCnt + 6'd1;
          result  <= resultNext;
          if (pendNext == '0) begin
            state      <= IDLE;
            wb_valid_o <= 1'b1;
            wb_load_o  <= loadQ;
            wb_warp_o  <= warpQ;
            wb_mask_o  <= maskQ;
            wb_data_o  <= wbDataNext;
            pass_cnt_o <= passCnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_o    = (state == ISSUE);
  assign conflict_o = wb_valid_o && (pass_cnt_o > 6'd1);
endmodule

// File: tb/tb_shared_mem_bank_replay.sv
// Self-checking bench for shared_mem_bank_replay: a directed vector table,
// hand-written reset/abort sequence, and randomized packets checked against
// a word-addressed reference memory and a per-bank pass-count model.
module tb_shared_mem_bank_replay;
  localparam int NL = 32, NB = 16, AW = 32, DW = 32, WW = 5, DEPTH = 256;
`ifdef SHARED_MEM_BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [NL*AW-1:0]    addrPkt;
  logic [NL*DW-1:0]    dataPkt;
  logic [NL+WW+1:0]    infoPkt;
  logic                stall, wbValid, wbLoad, conflict;
  logic [WW-1:0]       wbWarp;
  logic [NL-1:0]       wbMask;
  logic [NL*DW-1:0]    wbData;
  logic [5:0]          passCnt;

  shared_mem_bank_replay dut (
    .clk(clk), .reset(reset), .addr_pkt_i(addrPkt), .data_pkt_i(dataPkt),
    .info_pkt_i(infoPkt), .stall_o(stall), .wb_valid_o(wbValid),
    .wb_load_o(wbLoad), .wb_warp_o(wbWarp), .wb_mask_o(wbMask),
    .wb_data_o(wbData), .pass_cnt_o(passCnt), .conflict_o(conflict)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [DW-1:0] refMem [int];   // word index -> last stored value
  logic [AW-1:0] aL [NL];
  logic [DW-1:0] dL [NL];

  task automatic checkI(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic checkV(input string name, input logic [NL*DW-1:0] act, input logic [NL*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Caller sits at a negedge with the DUT idle. Drives one packet from aL/dL,
  // waits for its writeback, checks it against the model and returns still
  // at a negedge, so back-to-back calls run at full throughput.
  task automatic runPkt(input string tag, input bit load, input logic [NL-1:0] mask,
                        input logic [WW-1:0] warp, output int gotPass,
                        output logic [NL*DW-1:0] gotData);
    int cnt [NB];
    int wi [NL];
    int expPass, cyc, stallCnt;
    bit seen, first;
    logic [NL*DW-1:0] expD, cmpM;
    logic [63:0] r;

    expPass = 0;
    for (int b = 0; b < NB; b++) cnt[b] = 0;
    for (int i = 0; i < NL; i++) wi[i] = int'((aL[i] >> 2) % (NB*DEPTH));
    // Passes = worst bank: lanes per bank, or distinct words per bank for
    // broadcast loads.
    for (int i = 0; i < NL; i++) begin
      if (mask[i]) begin
        first = 1'b1;
        if (load && BCAST)
          for (int j = 0; j < i; j++) if (mask[j] && wi[j] == wi[i]) first = 1'b0;
        if (first) cnt[wi[i] % NB]++;
      end
    end
    for (int b = 0; b < NB; b++) if (cnt[b] > expPass) expPass = cnt[b];

    expD = '0;
    cmpM = '1;
    if (load) begin
      for (int i = 0; i < NL; i++) begin
        if (mask[i]) begin
          if (refMem.exists(wi[i])) expD[(NL-1-i)*DW +: DW] = refMem[wi[i]];
          else cmpM[(NL-1-i)*DW +: DW] = '0;
        end
      end
    end

    for (int i = 0; i < NL; i++) begin
      addrPkt[(NL-1-i)*AW +: AW] = aL[i];
      dataPkt[(NL-1-i)*DW +: DW] = dL[i];
    end
    infoPkt = {mask, warp, 1'b1, load};
    @(posedge clk);
    #1;
    infoPkt[1] = 1'b0;

    cyc = 0; stallCnt = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (stall) stallCnt++;
      if (wbValid) seen = 1'b1;
      else if (stall) begin
        // Junk offered while stalled must be ignored.
        r = {$urandom(), $urandom()};
        infoPkt = r[NL+WW+1:0];
        infoPkt[1] = 1'b1;
        addrPkt[AW-1:0] = $urandom();
      end
    end
    infoPkt[1] = 1'b0;

    if (!load)
      for (int i = 0; i < NL; i++) if (mask[i]) refMem[wi[i]] = dL[i];

    gotPass = int'(passCnt);
    gotData = wbData;
    checkI({tag, ":wb_seen"}, int'(seen), 1);
    if (seen) begin
      checkI({tag, ":latency"}, cyc, expPass + 1);
      checkI({tag, ":stall_cycles"}, stallCnt, expPass);
      checkI({tag, ":pass_cnt"}, int'(passCnt), expPass);
      checkI({tag, ":conflict"}, int'(conflict), int'(expPass > 1));
      checkI({tag, ":wb_load"}, int'(wbLoad), int'(load));
      checkI({tag, ":wb_warp"}, int'(wbWarp), int'(warp));
      checkI({tag, ":wb_mask"}, int'(wbMask), int'(mask));
      checkV({tag, ":wb_data"}, wbData & cmpM, expD);
    end
  endtask

  typedef struct {
    string         name;
    bit            load;
    logic [NL-1:0] mask;
    logic [WW-1:0] warp;
    logic [AW-1:0] abase;
    logic [AW-1:0] astride;
    logic [DW-1:0] dbase;   // lane i stores dbase + (i >> dsh)
    int            dsh;
    int            expPass;
    logic [DW-1:0] ebase;   // masked load lane i returns ebase + (i >> esh)
    int            esh;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int gp, wbSeen, stSeen;
    logic [NL*DW-1:0] gd, ed;
    logic [NL-1:0] m;
    int widx, sparse;
    logic [31:0] r;

    tbl[0] = '{"st_lin",  1'b0, '1, 5'd1, 32'h0,  32'd4, 32'h1000, 0, 2, 32'h0, 0};
    tbl[1] = '{"ld_lin",  1'b1, '1, 5'd2, 32'h0,  32'd4, 32'h0, 0, 2, 32'h1000, 0};
    tbl[2] = '{"st_str8", 1'b0, '1, 5'd3, 32'h0,  32'd8, 32'h2000, 0, 4, 32'h0, 0};
    tbl[3] = '{"ld_str8", 1'b1, '1, 5'd4, 32'h0,  32'd8, 32'h0, 0, 4, 32'h2000, 0};
    tbl[4] = '{"st_cafe", 1'b0, 32'h1, 5'd6, 32'h40, 32'd0, 32'hCAFE, 5, 1, 32'h0, 0};
    tbl[5] = '{"ld_cafe", 1'b1, '1, 5'd7, 32'h40, 32'd0, 32'h0, 0, BCAST ? 1 : 32, 32'hCAFE, 5};
    tbl[6] = '{"st_dup",  1'b0, 32'h88, 5'd8, 32'h80, 32'd0, 32'hA, 2, 2, 32'h0, 0};
    tbl[7] = '{"ld_dup",  1'b1, 32'h1, 5'd9, 32'h80, 32'd0, 32'h0, 0, 1, 32'hB, 5};
    tbl[8] = '{"empty",   1'b1, 32'h0, 5'd5, 32'h100, 32'd4, 32'h0, 0, 0, 32'h0, 0};

    reset = 1'b0;
    addrPkt = '0;
    dataPkt = '0;
    infoPkt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkI("rst:stall", int'(stall), 0);
    checkI("rst:wb_valid", int'(wbValid), 0);
    checkI("rst:pass_cnt", int'(passCnt), 0);
    checkV("rst:wb_data", wbData, '0);
    reset = 1'b1;

    // Directed vectors
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < NL; i++) begin
        aL[i] = tbl[k].abase + AW'(i) * tbl[k].astride;
        dL[i] = tbl[k].dbase + DW'(i >> tbl[k].dsh);
      end
      runPkt(tbl[k].name, tbl[k].load, tbl[k].mask, tbl[k].warp, gp, gd);
      ed = '0;
      if (tbl[k].load)
        for (int i = 0; i < NL; i++)
          if (tbl[k].mask[i]) ed[(NL-1-i)*DW +: DW] = tbl[k].ebase + DW'(i >> tbl[k].esh);
      checkI({tbl[k].name, ":tbl_pass"}, gp, tbl[k].expPass);
      checkV({tbl[k].name, ":tbl_data"}, gd, ed);
    end

    // Reset during pass 2 of a 4-pass load: no writeback ever appears.
    for (int i = 0; i < NL; i++) begin
      addrPkt[(NL-1-i)*AW +: AW] = AW'(8 * i);
    end
    infoPkt = {32'hFFFF_FFFF, 5'd3, 1'b1, 1'b1};
    @(posedge clk);
    #1;
    infoPkt[1] = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkI("abort:stall", int'(stall), 0);
    checkI("abort:wb_valid", int'(wbValid), 0);
    checkI("abort:wb_warp", int'(wbWarp), 0);
    checkI("abort:wb_load", int'(wbLoad), 0);
    checkI("abort:wb_mask", int'(wbMask), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    wbSeen = 0;
    stSeen = 0;
    repeat (8) begin
      @(negedge clk);
      if (wbValid) wbSeen++;
      if (stall) stSeen++;
    end
    checkI("abort:no_wb", wbSeen, 0);
    checkI("abort:no_stall", stSeen, 0);
    for (int i = 0; i < NL; i++) begin
      aL[i] = AW'(4 * i);
      dL[i] = '0;
    end
    runPkt("after_abort", 1'b1, '1, 5'd11, gp, gd);

    // Fill words 0..127 so every random load hits known data.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NL; i++) begin
        aL[i] = AW'(4 * (32 * k + i));
        dL[i] = $urandom();
      end
      runPkt("fill", 1'b0, '1, 5'(k), gp, gd);
    end

    // Random packets: upper/byte address bits random, word index either
    // spread or clustered to force conflicts and shared words.
    for (int n = 0; n < 40; n++) begin
      sparse = $urandom_range(0, 2);
      for (int i = 0; i < NL; i++) begin
        widx = (sparse == 0) ? $urandom_range(0, 7) : $urandom_range(0, 127);
        r = $urandom();
        aL[i] = (r & 32'hFFFF_C003) | (32'(widx) << 2);
        dL[i] = $urandom();
      end
      m = $urandom();
      case ($urandom_range(0, 7))
        0: m = '0;
        1: m = NL'(1) << $urandom_range(0, NL-1);
        default: ;
      endcase
      runPkt("rand", 1'($urandom_range(0, 1)), m, 5'($urandom_range(0, 31)), gp, gd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
